n64_read_response: RTL
======================

Name: n64_read_response

Overview:
- Receive-side companion to the N64 command writer.
- Sits directly downstream: once the writer releases the shared data line, this block listens for the controller's reply.
- Deserialises 32 response bits from the one-wire pulse-width encoded line and presents them as a parallel word with a one-cycle valid strobe.
- Times out cleanly if the controller is absent or the line is stuck.

Parameters:
- NUM_BITS, 32: response data bits per reply.
- SAMPLE_POINT, 200: clocks after a bit's falling edge at which the line is sampled (2 us at 100 MHz).
- FIRST_TIMEOUT, 1000: max clocks from start to the first falling edge.
- BIT_TIMEOUT, 600: max clocks from one bit's falling edge to the next falling edge, and max continuous low time.
- STOP_IDLE, 300: clocks of continuous high after the last data bit that mark the reply complete.

Ports:
- clk, input, 1: system clock, 100 MHz nominal.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle pulse; begin listening. Driven when the writer's writing_data falls.
- data_in, input, 1: raw line level, asynchronous to clk.
- response, output, NUM_BITS: received word. First bit received lands in response[NUM_BITS-1].
- valid, output, 1: one-cycle pulse; response is complete.
- busy, output, 1: high from the cycle after an accepted start until DONE/TIMEOUT exits.
- timeout, output, 1: one-cycle pulse; reply aborted.

Behaviour:
- Reset (async, active-high) values: response=0, valid=0, busy=0, timeout=0, state=IDLE, all counters=0, synchroniser flops=1 (line idles high).
- Synchroniser and edge detect:
  - data_in passes through 2 flops to give line_s; prev_s holds the previous line_s.
  - fall = prev_s & ~line_s.
  - Latency from a pin edge to fall is 3 clocks. Sample timing is measured from fall.
- IDLE:
  - busy=0.
  - On start, go to WAIT_EDGE with cnt=0 and bit_idx=0. The shift register is cleared only when the next reply begins.
  - start while not in IDLE is ignored.
- WAIT_EDGE:
  - cnt increments each clock.
  - On fall, go to LOW with cnt=0.
  - If cnt reaches the limit (FIRST_TIMEOUT when bit_idx==0, else BIT_TIMEOUT), go to TIMEOUT.
  - If fall and the limit coincide, fall wins.
- LOW:
  - cnt increments each clock.
  - When cnt==SAMPLE_POINT-1: shift line_s into the LSB of the shift register (MSB-first assembly) and increment bit_idx.
  - If bit_idx becomes NUM_BITS, go to WAIT_STOP with cnt=0. Otherwise go to WAIT_EDGE while keeping cnt, so the BIT_TIMEOUT budget is measured from the falling edge.
  - A fall inside LOW before the sample is a glitch and is ignored.
- WAIT_STOP:
  - Counts consecutive clocks with line_s=1. Any line_s=0 resets the count; this absorbs the controller's stop pulse.
  - Count reaching STOP_IDLE: go to DONE.
  - Line low for BIT_TIMEOUT consecutive clocks: go to TIMEOUT.
- DONE: for one cycle, response <= shift register and valid=1, then go to IDLE.
- TIMEOUT: for one cycle, timeout=1 and response unchanged, then go to IDLE.
- valid and timeout are never high in the same cycle.
- Counter width is clog2 of the largest timing parameter plus 1. bit_idx width is clog2(NUM_BITS)+1. No wrap is possible because every count is bounded by a timeout.
- Reset asserted mid-reply: immediate return to IDLE. No valid or timeout pulse is generated for the aborted reply.
- start pulsed in the same cycle valid or timeout fires: ignored, since the block is not yet in IDLE.

Decomposition:
- Package n64_pkg holds:
  - shared bit-cell timing constants, also used by the writer: START=100, DATA=300, STOP=400;
  - SAMPLE_POINT and the timeout defaults;
  - the state enum {IDLE, WAIT_EDGE, LOW, WAIT_STOP, DONE, TIMEOUT}.
- One sub-module, n64_line_sync: 2-flop synchroniser plus falling-edge detect, async reset to 1. It is reusable for the bidirectional pad wrapper.

Test Plan:
- Nominal: start, then 32 bits encoding 0x8000_1234 (each bit: 100 clk low + 300 high for '1', 300 low + 100 high for '0'), stop pulse 200 low, then line high -> valid pulses once, response=0x80001234, busy falls the same cycle valid returns to IDLE.
- No controller: start with line held high -> timeout pulse exactly FIRST_TIMEOUT+1 clocks after start; valid never asserted; response keeps its prior value.
- Truncated reply: only 16 bits sent, then line high -> timeout BIT_TIMEOUT clocks after the 16th falling edge.
- Stuck low: line driven low permanently after bit 5's falling edge -> timeout. Then a second start with a full reply 0xFFFF_FFFF -> valid with response=0xFFFFFFFF.
- Glitch and back-to-back: a 20-clock high glitch inside a '0' bit's low phase -> bit still reads 0. A start issued while busy -> ignored and the reply completes normally.
- Reset mid-reply: assert reset at bit 10 -> outputs zero immediately and no valid. After reset release, a fresh start plus reply 0x00000001 -> response=0x00000001.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared N64 one-wire timing constants and the read-response state encoding.
package n64_pkg;

  // Bit-cell edges in clocks from the falling edge, shared with the command writer.
  localparam int START = 100;
  localparam int DATA  = 300;
  localparam int STOP  = 400;

  localparam int NUM_BITS_DFLT      = 32;
  localparam int SAMPLE_POINT_DFLT  = 200;
  localparam int FIRST_TIMEOUT_DFLT = 1000;
  localparam int BIT_TIMEOUT_DFLT   = 600;
  localparam int STOP_IDLE_DFLT     = 300;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EDGE = 3'd1,
    LOW       = 3'd2,
    WAIT_STOP = 3'd3,
    DONE      = 3'd4,
    TIMEOUT   = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchroniser for the open-drain data line plus falling-edge detect.
module n64_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q;
  logic line_q;
  logic prev_q;

  // Line idles high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      line_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= data_i;
      line_q <= meta_q;
      prev_q <= line_q;
    end
  end

  assign line_o = line_q;
  assign fall_o = prev_q & ~line_q;

endmodule

// File: rtl/n64_read_response.sv
// Deserialises the controller's pulse-width encoded reply into a parallel word,
// with a one-cycle valid strobe or a one-cycle timeout strobe.
module n64_read_response
  import n64_pkg::*;
#(
  parameter int NUM_BITS      = NUM_BITS_DFLT,
  parameter int SAMPLE_POINT  = SAMPLE_POINT_DFLT,
  parameter int FIRST_TIMEOUT = FIRST_TIMEOUT_DFLT,
  parameter int BIT_TIMEOUT   = BIT_TIMEOUT_DFLT,
  parameter int STOP_IDLE     = STOP_IDLE_DFLT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                data_in,
  output logic [NUM_BITS-1:0] response,
  output logic                valid,
  output logic                busy,
  output logic                timeout
);

  localparam int CNT_W = $clog2(max_int(max_int(SAMPLE_POINT, FIRST_TIMEOUT),
                                        max_int(BIT_TIMEOUT, STOP_IDLE))) + 1;
  localparam int IDX_W = $clog2(NUM_BITS) + 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_POINT - 1);
  localparam logic [CNT_W-1:0] FIRST_LIM   = CNT_W'(FIRST_TIMEOUT);
  localparam logic [CNT_W-1:0] BIT_LIM     = CNT_W'(BIT_TIMEOUT);
  localparam logic [CNT_W-1:0] STOP_LIM    = CNT_W'(STOP_IDLE);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BITS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    low_cnt_q, low_cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [NUM_BITS-1:0] response_q, response_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic                line_s;
  logic                fall_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [CNT_W-1:0]    low_inc_s;
  logic [IDX_W-1:0]    idx_inc_s;
  logic [CNT_W-1:0]    limit_s;

  n64_line_sync u_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .data_i (data_in),
    .line_o (line_s),
    .fall_o (fall_s)
  );

  assign cnt_inc_s = cnt_q + CNT_W'(1);
  assign low_inc_s = low_cnt_q + CNT_W'(1);
  assign idx_inc_s = bit_idx_q + IDX_W'(1);
  assign limit_s   = (bit_idx_q == IDX_W'(0)) ? FIRST_LIM : BIT_LIM;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      low_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      response_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      low_cnt_q  <= low_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      response_q <= response_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state and datapath. cnt is carried from LOW into WAIT_EDGE so the
  // per-bit budget is measured from the falling edge, not from the sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    low_cnt_d = low_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT_EDGE;
          cnt_d     = '0;
          low_cnt_d = '0;
          bit_idx_d = '0;
          shreg_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_EDGE: begin
        cnt_d = cnt_inc_s;
        if (fall_s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_inc_s == limit_s) begin
          state_d = TIMEOUT;
        end else begin
          state_d = WAIT_EDGE;
        end
      end
      LOW: begin
        cnt_d = cnt_inc_s;
        if (cnt_q == SAMPLE_LAST) begin
          shreg_d   = {shreg_q[NUM_BITS-2:0], line_s};
          bit_idx_d = idx_inc_s;
          if (idx_inc_s == LAST_IDX) begin
            state_d   = WAIT_STOP;
            cnt_d     = '0;
            low_cnt_d = '0;
          end else begin
            state_d = WAIT_EDGE;
          end
        end else begin
          state_d = LOW;
        end
      end
      WAIT_STOP: begin
        if (line_s) begin
          cnt_d     = cnt_inc_s;
          low_cnt_d = '0;
          state_d   = (cnt_inc_s == STOP_LIM) ? DONE : WAIT_STOP;
        end else begin
          cnt_d     = '0;
          low_cnt_d = low_inc_s;
          state_d   = (low_inc_s == BIT_LIM) ? TIMEOUT : WAIT_STOP;
        end
      end
      DONE:    state_d = IDLE;
      TIMEOUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    valid_d    = (state_d == DONE);
    timeout_d  = (state_d == TIMEOUT);
    busy_d     = (state_d != IDLE);
    response_d = (state_d == DONE) ? shreg_q : response_q;
  end

  assign response = response_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
